mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have ports clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have ports reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have ports start, input, 1, request to execute op; accepted only when busy=0.
REQ-004 SHALL have ports op, input, 3, operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved/none.
REQ-005 SHALL have ports a, input, 32, rs operand; also the MTHI/MTLO write data.
REQ-006 SHALL have ports b, input, 32, rt operand.
REQ-007 SHALL have ports busy, output, 1, high while an operation is in flight; pipeline stalls HI/LO readers on it.
REQ-008 SHALL have ports done, output, 1, one-cycle pulse when HI/LO receive the final result.
REQ-009 SHALL have ports hi, output, 32, architectural HI register.
REQ-010 SHALL have ports lo, output, 32, architectural LO register.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, FIN.
REQ-012 SHALL, in IDLE with start=1, latch a, b and signedness, then transition to MUL (MULT/MULTU) or DIV (DIV/DIVU), with busy=1 from the next cycle.
REQ-013 SHALL treat start=1 with op 000 or 111 as a no-op: stay in IDLE, no done pulse.
REQ-014 SHALL, for MTHI/MTLO in IDLE, write a into hi/lo at the same edge, stay in IDLE, keep busy=0, and pulse done the following cycle.
REQ-015 SHALL ignore start while busy=1; the in-flight operation and latched operands are unaffected.
REQ-016 SHALL execute MUL and DIV iteratively, one bit per cycle, with a 6-bit counter for 32 iterations, then go to FIN.
REQ-017 SHALL, in FIN, write hi/lo, pulse done, drop busy, and return to IDLE; a start accepted at edge N gives done=1 in cycle N+33.
REQ-018 SHALL accept a new start in the cycle where done=1, because busy is already 0.
REQ-019 SHALL produce the full 64-bit product for MULT (signed) and MULTU (unsigned): hi = bits 63:32, lo = bits 31:0.
REQ-020 SHALL, for DIV/DIVU, set lo to the quotient truncated toward zero and hi to the remainder, which takes the sign of the dividend for DIV.
REQ-021 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-022 SHALL, on divide by zero (b=0), keep normal latency and produce lo=0xFFFFFFFF, hi=a.
REQ-023 SHALL change hi/lo only at FIN, at an MTHI/MTLO edge, or on reset.

Reset
REQ-024 SHALL, with reset=1 at an edge, force state to IDLE, counter to 0, hi=0, lo=0, busy=0, done=0.
REQ-025 SHALL let reset abort an in-flight operation with no done pulse, and reset SHALL take priority over start in the same cycle.

Configuration
REQ-026 SHALL support macro MULT_DIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational 64-bit multiplier, IDLE->FIN directly, done in cycle N+1.
- Undefined: multiply is iterative per REQ-016.
- Division is iterative in both builds.

Structure
REQ-027 SHALL take md_op_t (op encoding), md_state_t (FSM states) and the constant MD_ITERATIONS=32 from shared package mips_pkg.
REQ-028 SHALL implement division in sub-module div_core: restoring, unsigned, one bit per cycle, with sign fix-up done in mult_div_unit.

Verification
REQ-029 SHALL pass: MULT a=0xFFFFFFFE (-2), b=3 -> done at N+33 (N+1 with MULT_DIV_FAST_MUL_EN), hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 SHALL pass: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL pass: DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-032 SHALL pass: start DIVU 100/7, then start MULT at N+5 -> second start ignored; at N+33 lo=14, hi=2, one done pulse.
REQ-033 SHALL pass: MTHI a=0x12345678 -> hi=0x12345678 after one edge, busy stays 0, done at N+1; lo unchanged.
REQ-034 SHALL pass: reset asserted at N+10 of a DIV -> next cycle busy=0, done=0, hi=lo=0; a new MULT 3*4 then gives lo=12.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the HI/LO multiply/divide unit: op encoding,
// FSM state encoding and iteration count, plus a small magnitude helper.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIN  = 2'b11
  } md_state_t;

  localparam logic [5:0] MD_ITERATIONS = 6'd32;

  // Absolute value of a 32-bit operand when treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      mag32 = 32'd0 - v;
    end else begin
      mag32 = v;
    end
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit_div_core.sv
// div_core: unsigned restoring divider, one quotient bit per step.
// After 32 steps quotient/remainder hold the result; divisor 0 yields all-ones.
module div_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [32:0] shifted_s;
  logic [31:0] diff_s;
  logic        ge_s;

  // Trial subtraction; the true difference always fits 32 bits when ge_s is set.
  always_comb begin
    shifted_s = {rem_r, quo_r[31]};
    ge_s      = (shifted_s >= {1'b0, dvs_r});
    diff_s    = shifted_s[31:0] - dvs_r;
  end

  // Remainder/quotient shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r <= 32'd0;
      quo_r <= 32'd0;
      dvs_r <= 32'd0;
    end else if (load) begin
      rem_r <= 32'd0;
      quo_r <= dividend;
      dvs_r <= divisor;
    end else if (step) begin
      if (ge_s) begin
        rem_r <= diff_s;
        quo_r <= {quo_r[30:0], 1'b1};
      end else begin
        rem_r <= shifted_s[31:0];
        quo_r <= {quo_r[30:0], 1'b0};
      end
    end else begin
      rem_r <= rem_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO.
// Optional MULT_DIV_FAST_MUL_EN selects a single-cycle multiplier.
module mult_div_unit
  import mips_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave md
);

  md_state_t   state_r, state_s;
  md_op_t      op_s;
  logic        ld_mul_s, ld_div_s, mt_hi_s, mt_lo_s, fin_s;
  logic        sgn_s;
  logic [31:0] mag_a_s, mag_b_s;

  logic [5:0]  cnt_r;
  logic [63:0] prod_r;
  logic [31:0] mcand_r;
  logic [32:0] mul_sum_s;
  logic        is_mul_r, neg_prod_r, neg_quo_r, neg_rem_r, b_zero_r;
  logic [31:0] a_r;
  logic [31:0] quo_s, rem_s;
  logic [63:0] mul_res_s;
  logic [31:0] res_hi_s, res_lo_s;
  logic        busy_r, done_r, mt_pend_r;
  logic [31:0] hi_r, lo_r;

  assign op_s    = md_op_t'(md.op);
  assign sgn_s   = (op_s == OP_MULT) || (op_s == OP_DIV);
  assign mag_a_s = mag32(md.a, sgn_s);
  assign mag_b_s = mag32(md.b, sgn_s);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and one-cycle control strobes.
  always_comb begin
    state_s  = state_r;
    ld_mul_s = 1'b0;
    ld_div_s = 1'b0;
    mt_hi_s  = 1'b0;
    mt_lo_s  = 1'b0;
    fin_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (md.start) begin
          case (op_s)
            OP_MULT, OP_MULTU: begin
              ld_mul_s = 1'b1;
`ifdef MULT_DIV_FAST_MUL_EN
              state_s  = FIN;
`else
              state_s  = MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              ld_div_s = 1'b1;
              state_s  = DIV;
            end
            OP_MTHI: mt_hi_s = 1'b1;
            OP_MTLO: mt_lo_s = 1'b1;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (cnt_r == MD_ITERATIONS - 6'd1) begin
          state_s = FIN;
        end else begin
          state_s = state_r;
        end
      end
      FIN: begin
        fin_s   = 1'b1;
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  div_core u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (ld_div_s),
    .step      (state_r == DIV),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Sign fix-up of the magnitude results; divide by zero overrides.
  always_comb begin
    mul_sum_s = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, mcand_r} : 33'd0);
    mul_res_s = neg_prod_r ? (64'd0 - prod_r) : prod_r;
    if (is_mul_r) begin
      res_hi_s = mul_res_s[63:32];
      res_lo_s = mul_res_s[31:0];
    end else if (b_zero_r) begin
      res_hi_s = a_r;
      res_lo_s = 32'hFFFF_FFFF;
    end else begin
      res_hi_s = neg_rem_r ? (32'd0 - rem_s) : rem_s;
      res_lo_s = neg_quo_r ? (32'd0 - quo_s) : quo_s;
    end
  end

  // Datapath, operand latches and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= 6'd0;
      prod_r     <= 64'd0;
      mcand_r    <= 32'd0;
      is_mul_r   <= 1'b0;
      neg_prod_r <= 1'b0;
      neg_quo_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      b_zero_r   <= 1'b0;
      a_r        <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mt_pend_r  <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      mt_pend_r <= mt_hi_s | mt_lo_s;
      done_r    <= fin_s | mt_pend_r;
      if (ld_mul_s || ld_div_s) begin
        cnt_r  <= 6'd0;
        busy_r <= 1'b1;
      end else if (state_r == MUL || state_r == DIV) begin
        cnt_r  <= cnt_r + 6'd1;
      end else if (fin_s) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r;
      end
      if (ld_mul_s) begin
        is_mul_r   <= 1'b1;
        neg_prod_r <= sgn_s & (md.a[31] ^ md.b[31]);
        mcand_r    <= mag_a_s;
`ifdef MULT_DIV_FAST_MUL_EN
        prod_r     <= {32'd0, mag_a_s} * {32'd0, mag_b_s};
`else
        prod_r     <= {32'd0, mag_b_s};
`endif
      end else if (state_r == MUL) begin
        prod_r     <= {mul_sum_s, prod_r[31:1]};
      end else begin
        prod_r     <= prod_r;
      end
      if (ld_div_s) begin
        is_mul_r   <= 1'b0;
        neg_quo_r  <= sgn_s & (md.a[31] ^ md.b[31]);
        neg_rem_r  <= sgn_s & md.a[31];
        b_zero_r   <= (md.b == 32'd0);
        a_r        <= md.a;
      end
      if (fin_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else if (mt_hi_s) begin
        hi_r <= md.a;
      end else if (mt_lo_s) begin
        lo_r <= md.a;
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  assign md.busy = busy_r;
  assign md.done = done_r;
  assign md.hi   = hi_r;
  assign md.lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; follows MULT_DIV_FAST_MUL_EN for multiply latency.
module tb_mult_div_unit;
  import mips_pkg::*;

`ifdef MULT_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errs = 0;
  int   pulses;

  mult_div_unit_if mdi ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdi.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one start for a single edge, then release it.
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    mdi.start = 1'b1;
    mdi.op    = op;
    mdi.a     = a;
    mdi.b     = b;
    tick();
    mdi.start = 1'b0;
  endtask

  // Called in cycle N; returns in cycle N+lat (the done cycle).
  task automatic wait_done(input string tag, input int lat);
    repeat (lat - 1) tick();
    chk({tag, "_predone"}, {30'd0, mdi.busy, mdi.done}, 32'd2);
    tick();
    chk({tag, "_done"}, {30'd0, mdi.busy, mdi.done}, 32'd1);
  endtask

  initial begin
    mdi.start = 1'b0;
    mdi.op    = 3'b000;
    mdi.a     = 32'd0;
    mdi.b     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_ctrl", {30'd0, mdi.busy, mdi.done}, 32'd0);
    chk("reset_hi", mdi.hi, 32'd0);
    chk("reset_lo", mdi.lo, 32'd0);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult_m2x3", MUL_LAT);
    chk("mult_m2x3_hi", mdi.hi, 32'hFFFF_FFFF);
    chk("mult_m2x3_lo", mdi.lo, 32'hFFFF_FFFA);

    // Back-to-back start in the done cycle.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_accept", {30'd0, mdi.busy, mdi.done}, 32'd2);
    wait_done("multu_max", MUL_LAT);
    chk("multu_max_hi", mdi.hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", mdi.lo, 32'h0000_0001);
    tick();
    chk("done_one_cycle", {31'd0, mdi.done}, 32'd0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_done("mult_neg_neg", MUL_LAT);
    chk("mult_neg_neg_hi", mdi.hi, 32'd0);
    chk("mult_neg_neg_lo", mdi.lo, 32'd15);

    issue(OP_MULT, 32'h8000_0000, 32'd2);
    wait_done("mult_min", MUL_LAT);
    chk("mult_min_hi", mdi.hi, 32'hFFFF_FFFF);
    chk("mult_min_lo", mdi.lo, 32'd0);

    issue(OP_MULTU, 32'h8000_0000, 32'd2);
    wait_done("multu_min", MUL_LAT);
    chk("multu_min_hi", mdi.hi, 32'd1);
    chk("multu_min_lo", mdi.lo, 32'd0);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7", DIV_LAT);
    chk("div_m7_hi", mdi.hi, 32'hFFFF_FFFF);
    chk("div_m7_lo", mdi.lo, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done("divu_zero", DIV_LAT);
    chk("divu_zero_hi", mdi.hi, 32'd7);
    chk("divu_zero_lo", mdi.lo, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DIV_LAT);
    chk("div_ovf_hi", mdi.hi, 32'd0);
    chk("div_ovf_lo", mdi.lo, 32'h8000_0000);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_zero", DIV_LAT);
    chk("div_zero_hi", mdi.hi, 32'hFFFF_FFF9);
    chk("div_zero_lo", mdi.lo, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'd20, 32'hFFFF_FFFD);
    wait_done("div_pos_neg", DIV_LAT);
    chk("div_pos_neg_hi", mdi.hi, 32'd2);
    chk("div_pos_neg_lo", mdi.lo, 32'hFFFF_FFFA);

    // DIVU 100/7 with a MULT presented at edge N+5 that must be ignored.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    issue(OP_MULT, 32'd5, 32'd5);
    chk("midop_hi", mdi.hi, 32'd2);
    chk("midop_lo", mdi.lo, 32'hFFFF_FFFA);
    repeat (27) tick();
    chk("divu_100_predone", {30'd0, mdi.busy, mdi.done}, 32'd2);
    tick();
    chk("divu_100_done", {30'd0, mdi.busy, mdi.done}, 32'd1);
    chk("divu_100_hi", mdi.hi, 32'd2);
    chk("divu_100_lo", mdi.lo, 32'd14);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mdi.done === 1'b1) pulses++;
    end
    chk("ignored_start_pulses", pulses, 32'd0);
    chk("ignored_start_busy", {31'd0, mdi.busy}, 32'd0);

    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", mdi.hi, 32'h1234_5678);
    chk("mthi_ctrl0", {30'd0, mdi.busy, mdi.done}, 32'd0);
    tick();
    chk("mthi_ctrl1", {30'd0, mdi.busy, mdi.done}, 32'd1);
    chk("mthi_lo", mdi.lo, 32'd14);
    tick();
    chk("mthi_ctrl2", {31'd0, mdi.done}, 32'd0);

    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", mdi.lo, 32'hCAFE_F00D);
    chk("mtlo_hi", mdi.hi, 32'h1234_5678);
    tick();
    chk("mtlo_done", {31'd0, mdi.done}, 32'd1);

    issue(OP_NONE, 32'h1111_1111, 32'd1);
    chk("nop0_busy", {31'd0, mdi.busy}, 32'd0);
    issue(OP_RSVD, 32'h2222_2222, 32'd1);
    chk("nop7_ctrl", {30'd0, mdi.busy, mdi.done}, 32'd0);
    tick();
    chk("nop_done", {31'd0, mdi.done}, 32'd0);
    chk("nop_hi", mdi.hi, 32'h1234_5678);
    chk("nop_lo", mdi.lo, 32'hCAFE_F00D);

    // Reset at edge N+10 of a DIV aborts it.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ctrl", {30'd0, mdi.busy, mdi.done}, 32'd0);
    chk("abort_hi", mdi.hi, 32'd0);
    chk("abort_lo", mdi.lo, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mdi.done === 1'b1) pulses++;
    end
    chk("abort_pulses", pulses, 32'd0);

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    issue(OP_MULT, 32'd9, 32'd9);
    reset = 1'b0;
    chk("rst_prio_busy", {31'd0, mdi.busy}, 32'd0);

    issue(OP_MULT, 32'd3, 32'd4);
    wait_done("mult_3x4", MUL_LAT);
    chk("mult_3x4_hi", mdi.hi, 32'd0);
    chk("mult_3x4_lo", mdi.lo, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
